// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Optional macro CLKDIV_SYNC_EN adds a global phase-align clear (see clkdiv_chan).
package clkdiv_pkg;

    localparam int CLKDIV_CNT_W       = 32;
    localparam int CLKDIV_DEFAULT_DIV = 5000000;

    // Half-period terminal counts for a 100 MHz system clock
    localparam int DIV_10HZ = 4999999;
    localparam int DIV_1HZ  = 49999999;
    localparam int DIV_2HZ  = 24999999;

    function automatic int clkdiv_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_multi_if.sv
// Control/status bundle between a divider user and clkdiv_multi.
// Macro CLKDIV_SYNC_EN adds the sync_clr request line.
interface clkdiv_multi_if
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CLKDIV_CNT_W
);
    localparam int CH_W = clkdiv_ch_w(NUM_CH);

    logic [NUM_CH-1:0] en;
    logic              ld_valid;
    logic [CH_W-1:0]   ld_ch;
    logic [CNT_W-1:0]  ld_div;
    logic              ld_ready;
    logic [NUM_CH-1:0] clk_div;
    logic [NUM_CH-1:0] tick;
`ifdef CLKDIV_SYNC_EN
    logic              sync_clr;
`endif

    modport master (
`ifdef CLKDIV_SYNC_EN
        output sync_clr,
`endif
        output en, ld_valid, ld_ch, ld_div,
        input  ld_ready, clk_div, tick
    );

    modport slave (
`ifdef CLKDIV_SYNC_EN
        input  sync_clr,
`endif
        input  en, ld_valid, ld_ch, ld_div,
        output ld_ready, clk_div, tick
    );

endinterface

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, active/shadow divide values, registered outputs.
// With CLKDIV_SYNC_EN, i_sync_clr restarts the channel at phase zero.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = CLKDIV_CNT_W,
    parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_ld_stb,
    input  logic [CNT_W-1:0] i_ld_div,
`ifdef CLKDIV_SYNC_EN
    input  logic             i_sync_clr,
`endif
    output logic             o_pending,
    output logic             o_clk_div,
    output logic             o_tick
);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_clk_div;
    logic             r_tick;
    logic             w_sync;

`ifdef CLKDIV_SYNC_EN
    assign w_sync = i_sync_clr;
`else
    assign w_sync = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_div     <= DEF_DIV;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_clk_div <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            if (w_sync) begin
                r_cnt     <= '0;
                r_clk_div <= 1'b0;
                r_tick    <= 1'b0;
                if (r_pending) begin
                    r_div     <= r_shadow;
                    r_pending <= 1'b0;
                end
            end else if (i_en) begin
                if (r_cnt == r_div) begin
                    r_cnt     <= '0;
                    r_clk_div <= ~r_clk_div;
                    r_tick    <= 1'b1;
                    if (r_pending) begin
                        r_div     <= r_shadow;
                        r_pending <= 1'b0;
                    end
                end else begin
                    r_cnt  <= r_cnt + ONE;
                    r_tick <= 1'b0;
                end
            end else begin
                // Disabled: safe moment to swap in a pending value, count is kept
                r_tick <= 1'b0;
                if (r_pending) begin
                    r_div     <= r_shadow;
                    r_pending <= 1'b0;
                end
            end
            // A load is only accepted while nothing is pending, so it never races an apply
            if (i_ld_stb) begin
                r_shadow  <= i_ld_div;
                r_pending <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_clk_div = r_clk_div;
    assign o_tick    = r_tick;

endmodule

// File: rtl/clkdiv_multi.sv
// NUM_CH independent glitch-free clock dividers with a shared valid/ready reload port.
// Macro CLKDIV_SYNC_EN adds bus.sync_clr to phase-align all channels.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CLKDIV_CNT_W,
    parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
    input  logic           clk,
    input  logic           rst,
    clkdiv_multi_if.slave  bus
);
    localparam int CH_W = clkdiv_ch_w(NUM_CH);

    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_ld_stb;
    logic [NUM_CH-1:0] w_clk_div;
    logic [NUM_CH-1:0] w_tick;
    logic              w_ld_ready;

    // Out-of-range channel indices match no entry and leave ready low
    always_comb begin
        w_ld_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ld_ch == CH_W'(i)) begin
                w_ld_ready = ~w_pending[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign w_ld_stb[g] = bus.ld_valid & w_ld_ready & (bus.ld_ch == CH_W'(g));

            clkdiv_chan #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .i_en       (bus.en[g]),
                .i_ld_stb   (w_ld_stb[g]),
                .i_ld_div   (bus.ld_div),
`ifdef CLKDIV_SYNC_EN
                .i_sync_clr (bus.sync_clr),
`endif
                .o_pending  (w_pending[g]),
                .o_clk_div  (w_clk_div[g]),
                .o_tick     (w_tick[g])
            );
        end
    endgenerate

    assign bus.ld_ready = w_ld_ready;
    assign bus.clk_div  = w_clk_div;
    assign bus.tick     = w_tick;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: 3 channels (non power of two), 8-bit counters, reset divide of 3.
// Builds with or without CLKDIV_SYNC_EN.
module tb_clkdiv_multi;
    import clkdiv_pkg::*;

    localparam int NCH  = 3;
    localparam int CW   = 8;
    localparam int DDIV = 3;
    localparam int CHW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clkdiv_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    clkdiv_multi #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [NCH-1:0] d_en;
    bit             d_vld;
    int             d_ch;
    int             d_div;
    bit             d_sync;

    // Reference state, straight from the behavioural rules
    int m_cnt [NCH];
    int m_div [NCH];
    int m_sh  [NCH];
    bit m_pend[NCH];
    bit m_clk [NCH];
    bit m_tick[NCH];
    bit th[$];

    typedef struct {
        logic [NCH-1:0] en;
        logic [NCH-1:0] exp_clk;
        logic [NCH-1:0] exp_tick;
    } vec_t;
    vec_t vec[16];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [NCH-1:0] en, input bit v, input int ch, input int dv, input bit sc);
        d_en = en; d_vld = v; d_ch = ch; d_div = dv; d_sync = sc;
        bus.en       = en;
        bus.ld_valid = v;
        bus.ld_ch    = CHW'(ch);
        bus.ld_div   = CW'(dv);
`ifdef CLKDIV_SYNC_EN
        bus.sync_clr = sc;
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_div[i] = DDIV; m_sh[i] = 0;
            m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
        end
    endtask

    function automatic bit model_ready();
        if (d_ch >= NCH) return 1'b0;
        return !m_pend[d_ch];
    endfunction

    task automatic model_step();
        bit acc;
        bit sync_eff;
        acc = d_vld && model_ready();
        sync_eff = 1'b0;
`ifdef CLKDIV_SYNC_EN
        sync_eff = d_sync;
`endif
        for (int i = 0; i < NCH; i++) begin
            bit apply;
            apply = 1'b0;
            if (sync_eff) begin
                m_cnt[i] = 0; m_clk[i] = 0; m_tick[i] = 0; apply = 1'b1;
            end else if (d_en[i]) begin
                if (m_cnt[i] == m_div[i]) begin
                    m_clk[i] = !m_clk[i]; m_tick[i] = 1; m_cnt[i] = 0; apply = 1'b1;
                end else begin
                    m_cnt[i] = (m_cnt[i] + 1) % (1 << CW); m_tick[i] = 0;
                end
            end else begin
                m_tick[i] = 0; apply = 1'b1;
            end
            if (apply && m_pend[i]) begin
                m_div[i] = m_sh[i]; m_pend[i] = 0;
            end
        end
        if (acc) begin
            m_sh[d_ch] = d_div; m_pend[d_ch] = 1;
        end
    endtask

    // One clock: check ready before the edge, advance model on it, check outputs after
    task automatic cyc();
        #1;
        chk("ld_ready", bus.ld_ready, model_ready());
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < NCH; i++) begin
            chk("clk_div", bus.clk_div[i], m_clk[i]);
            chk("tick", bus.tick[i], m_tick[i]);
        end
        th.push_back(bus.tick[0]);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in('0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        th.delete();
    endtask

    task automatic chk_ticks(input string nm, input int mask, input int n);
        for (int e = 1; e <= n; e++) chk(nm, th[e-1], (mask >> e) & 1);
    endtask

    initial begin
        set_in('0, 0, 0, 0, 0);
        model_reset();
        #2;
        chk("reset_clk_div", bus.clk_div, 0);
        chk("reset_tick", bus.tick, 0);
        chk("reset_ld_ready", bus.ld_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Default divide 3, only ch0 running: toggle every 4 edges
        for (int k = 0; k < 16; k++) begin
            vec[k].en       = 3'b001;
            vec[k].exp_clk  = {2'b00, 1'(((k + 1) / 4) % 2)};
            vec[k].exp_tick = {2'b00, 1'(((k + 1) % 4) == 0)};
        end
        for (int k = 0; k < 16; k++) begin
            set_in(vec[k].en, 0, 0, 0, 0);
            cyc();
            chk("vec_clk", bus.clk_div, vec[k].exp_clk);
            chk("vec_tick", bus.tick, vec[k].exp_tick);
        end

        // Load mid-count at cnt=1: current half stays 4, then halves of 2
        do_reset();
        set_in(3'b001, 0, 0, 0, 0); cyc();
        set_in(3'b001, 1, 0, 1, 0); cyc();
        set_in(3'b001, 0, 0, 0, 0);
        #1 chk("midload_rdy_low", bus.ld_ready, 0);
        run(8);
        chk("midload_rdy_back", bus.ld_ready, 1);
        chk_ticks("midload_ticks", (1 << 4) | (1 << 6) | (1 << 8) | (1 << 10), 10);

        // Load on the wrap edge: old div for two more halves
        do_reset();
        set_in(3'b001, 0, 0, 0, 0); run(3);
        set_in(3'b001, 1, 0, 1, 0); cyc();
        set_in(3'b001, 0, 0, 0, 0); run(8);
        chk_ticks("wrapload_ticks", (1 << 4) | (1 << 8) | (1 << 10) | (1 << 12), 12);

        // div=0 loaded while disabled, then enabled: clk/2 with tick every cycle
        do_reset();
        set_in(3'b000, 1, 1, 0, 0); cyc();
        set_in(3'b000, 0, 0, 0, 0); cyc();
        set_in(3'b010, 0, 0, 0, 0);
        for (int j = 0; j < 6; j++) begin
            cyc();
            chk("div0_tick", bus.tick[1], 1);
            chk("div0_clk", bus.clk_div[1], (j + 1) % 2);
        end

        // Out-of-range channel index is refused and changes nothing
        set_in(3'b111, 1, 3, 0, 0);
        #1 chk("badch_rdy", bus.ld_ready, 0);
        run(8);

        // Asynchronous reset with a load pending
        do_reset();
        set_in(3'b001, 0, 0, 0, 0); run(5);
        set_in(3'b001, 1, 0, 1, 0); cyc();
        set_in(3'b001, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_clk_div", bus.clk_div, 0);
        chk("arst_tick", bus.tick, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        th.delete();
        run(8);
        chk_ticks("arst_default_div", (1 << 4) | (1 << 8), 8);

        // Randomised traffic against the reference model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            logic [NCH-1:0] en_r;
            en_r = ($urandom_range(0, 5) == 0) ? NCH'($urandom) : '1;
            set_in(en_r, $urandom_range(0, 2) == 0, $urandom_range(0, 3),
                   $urandom_range(0, 6), $urandom_range(0, 40) == 0);
            cyc();
        end

`ifdef CLKDIV_SYNC_EN
        do_reset();
        for (int c = 0; c < NCH; c++) begin
            set_in(3'b000, 1, c, 2, 0); cyc();
        end
        set_in(3'b101, 0, 0, 0, 0); run(7);
        set_in(3'b111, 0, 0, 0, 1); cyc();
        chk("sync_clr_all0", bus.clk_div, 0);
        set_in(3'b111, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            cyc();
            chk("sync_aligned", bus.clk_div, m_clk[0] ? 7 : 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
